wb_uart: RTL and testbench

//  Wishbone-slave 8N1 UART: programmable baud divisor, 2^LGFLEN-deep RX/TX FIFOs,

---
 rtl/wb_uart.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_wb_uart.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart.sv
// wb_uart: Wishbone-slave 8N1 UART with programmable divisor, RX/TX byte
// FIFOs, optional RTS/CTS flow control and four level interrupts.

// Byte FIFO shared by the receive and transmit paths.
module wb_uart_fifo #(
  parameter int LGFLEN = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_push,
  input  logic [7:0]        i_data,
  input  logic              i_pop,
  output logic [7:0]        o_data,
  output logic [LGFLEN:0]   o_fill,
  output logic              o_empty,
  output logic              o_full
);
  localparam int DEPTH = 1 << LGFLEN;

  logic [7:0]        mem [DEPTH];
  logic [LGFLEN-1:0] wr_ptr;
  logic [LGFLEN-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A pop on empty is ignored; a push on full is accepted only alongside a pop.
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  // Storage write port.
  // NOTE: the storage array is deliberately left out of reset; only the
  // pointers and fill count need a known value, and resetting the array would
  // prevent it from mapping onto RAM.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_data;
  end

  // Pointers and fill count.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_fill <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + LGFLEN'(1);
      if (do_pop)  rd_ptr <= rd_ptr + LGFLEN'(1);
      case ({do_push, do_pop})
        2'b10:   o_fill <= o_fill + (LGFLEN+1)'(1);
        2'b01:   o_fill <= o_fill - (LGFLEN+1)'(1);
        default: ;
      endcase
    end
  end

  assign o_data  = mem[rd_ptr];
  assign o_empty = (o_fill == '0);
  assign o_full  = o_fill[LGFLEN];
endmodule

module wb_uart #(
  parameter logic [31:0] INIT_SETUP = 32'h4000_0364,
  parameter int          LGFLEN     = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [1:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_stall,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  input  logic        i_uart_rx,
  output logic        o_uart_tx,
  input  logic        i_cts_n,
  output logic        o_rts_n,
  output logic        o_uart_rx_int,
  output logic        o_uart_tx_int,
  output logic        o_uart_rxfifo_int,
  output logic        o_uart_txfifo_int
);
  localparam logic [LGFLEN:0] HALF_FILL = (LGFLEN+1)'(1 << (LGFLEN-1));

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  // Bus decode
  logic        req, wr, rd;
  logic [31:0] rd_data;

  // Configuration and sticky errors
  logic        setup_flow;
  logic [23:0] setup_div;
  logic [23:0] eff_div;
  logic        rx_overflow;
  logic        rx_frame_err;

  // Synchronisers
  logic rx_meta, rx_s, rx_prev;
  logic cts_meta, cts_s;

  // FIFO interfaces
  logic [7:0]        rx_head, tx_head;
  logic [LGFLEN:0]   rx_fill, tx_fill;
  logic              rx_empty, rx_full, tx_empty, tx_full;
  logic              rx_pop, tx_push;

  // Receiver
  rx_state_t   rx_state, rx_state_d;
  logic [23:0] rx_cnt, rx_cnt_d;
  logic [2:0]  rx_bits, rx_bits_d;
  logic [7:0]  rx_shift, rx_shift_d;
  logic        rx_push, rx_ferr_set, rx_ovf_set;

  // Transmitter
  tx_state_t   tx_state, tx_state_d;
  logic [23:0] tx_cnt, tx_cnt_d;
  logic [2:0]  tx_bits, tx_bits_d;
  logic [7:0]  tx_shift, tx_shift_d;
  logic        tx_out, tx_out_d;
  logic        tx_pop, tx_start_ok, tx_busy;

  logic rts_q;
  logic unused_bits;

  assign unused_bits = ^{i_wb_sel, i_wb_data[31], i_wb_data[29:24]};

  assign req     = i_wb_cyc && i_wb_stb;
  assign wr      = req && i_wb_we;
  assign rd      = req && !i_wb_we;
  assign rx_pop  = rd && (i_wb_addr == 2'd2);
  assign tx_push = wr && (i_wb_addr == 2'd3);

  // A divisor below 2 would leave no room for a mid-bit sample point.
  assign eff_div = (setup_div < 24'd2) ? 24'd2 : setup_div;

  // Two-flop synchronisers for the asynchronous line inputs; rx_prev gives edge detect.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      cts_meta <= 1'b1;
      cts_s    <= 1'b1;
    end else begin
      rx_meta  <= i_uart_rx;
      rx_s     <= rx_meta;
      rx_prev  <= rx_s;
      cts_meta <= i_cts_n;
      cts_s    <= cts_meta;
    end
  end

  // Setup register and sticky receive errors; a write to RXDATA clears the errors.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      setup_flow   <= INIT_SETUP[30];
      setup_div    <= INIT_SETUP[23:0];
      rx_overflow  <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (wr && (i_wb_addr == 2'd0)) begin
        setup_flow <= i_wb_data[30];
        setup_div  <= i_wb_data[23:0];
      end
      if (wr && (i_wb_addr == 2'd2)) begin
        rx_overflow  <= 1'b0;
        rx_frame_err <= 1'b0;
      end else begin
        if (rx_ovf_set)  rx_overflow  <= 1'b1;
        if (rx_ferr_set) rx_frame_err <= 1'b1;
      end
    end
  end

  wb_uart_fifo #(.LGFLEN(LGFLEN)) u_rx_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (rx_push),
    .i_data  (rx_shift),
    .i_pop   (rx_pop),
    .o_data  (rx_head),
    .o_fill  (rx_fill),
    .o_empty (rx_empty),
    .o_full  (rx_full)
  );

  wb_uart_fifo #(.LGFLEN(LGFLEN)) u_tx_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (tx_push),
    .i_data  (i_wb_data[7:0]),
    .i_pop   (tx_pop),
    .o_data  (tx_head),
    .o_fill  (tx_fill),
    .o_empty (tx_empty),
    .o_full  (tx_full)
  );

  // A received byte is lost only when the FIFO is full and no read frees a slot.
  assign rx_ovf_set = rx_push && rx_full && !rx_pop;

  // Receiver state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_bits  <= rx_bits_d;
      rx_shift <= rx_shift_d;
    end
  end

  // Receiver next state: half-bit start qualification, then one sample per bit time.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rx_state_d  = rx_state;
    rx_cnt_d    = rx_cnt;
    rx_bits_d   = rx_bits;
    rx_shift_d  = rx_shift;
    rx_push     = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s) begin
          rx_state_d = RX_START;
          rx_cnt_d   = (eff_div >> 1) - 24'd1;
        end
      end
      RX_START: begin
        if (rx_cnt != '0) begin
          rx_cnt_d = rx_cnt - 24'd1;
        end else if (!rx_s) begin
          rx_state_d = RX_DATA;
          rx_cnt_d   = eff_div - 24'd1;
          rx_bits_d  = '0;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (rx_cnt != '0) begin
          rx_cnt_d = rx_cnt - 24'd1;
        end else begin
          rx_shift_d = {rx_s, rx_shift[7:1]};
          rx_cnt_d   = eff_div - 24'd1;
          rx_bits_d  = rx_bits + 3'd1;
          if (rx_bits == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt != '0) begin
          rx_cnt_d = rx_cnt - 24'd1;
        end else if (rx_s) begin
          rx_push    = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          rx_ferr_set = 1'b1;
          rx_state_d  = RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // CTS is only consulted when a new frame is about to begin.
  assign tx_start_ok = !tx_empty && (!setup_flow || !cts_s);
  assign tx_busy     = (tx_state != TX_IDLE);

  // Transmitter state register, including the registered line output.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_shift <= '0;
      tx_out   <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bits  <= tx_bits_d;
      tx_shift <= tx_shift_d;
      tx_out   <= tx_out_d;
    end
  end

  // Transmitter next state: start, 8 data bits LSB first, stop; chains frames without a gap.
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_bits_d  = tx_bits;
    tx_shift_d = tx_shift;
    tx_out_d   = tx_out;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_out_d = 1'b1;
        if (tx_start_ok) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_out_d   = 1'b0;
          tx_cnt_d   = eff_div - 24'd1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt != '0) begin
          tx_cnt_d = tx_cnt - 24'd1;
        end else begin
          tx_out_d   = tx_shift[0];
          tx_shift_d = {1'b0, tx_shift[7:1]};
          tx_bits_d  = '0;
          tx_cnt_d   = eff_div - 24'd1;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt != '0) begin
          tx_cnt_d = tx_cnt - 24'd1;
        end else begin
          tx_cnt_d = eff_div - 24'd1;
          if (tx_bits == 3'd7) begin
            tx_out_d   = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_out_d   = tx_shift[0];
            tx_shift_d = {1'b0, tx_shift[7:1]};
            tx_bits_d  = tx_bits + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt != '0) begin
          tx_cnt_d = tx_cnt - 24'd1;
        end else if (tx_start_ok) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_out_d   = 1'b0;
          tx_cnt_d   = eff_div - 24'd1;
          tx_state_d = TX_START;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Read-data multiplexer, evaluated on the request cycle.
  always_comb begin
    rd_data = '0;
    case (i_wb_addr)
      2'd0: rd_data = {1'b0, setup_flow, 6'b0, setup_div};
      2'd1: begin
        rd_data[31:28] = 4'(LGFLEN);
        rd_data[24:20] = 5'(rx_fill);
        rd_data[17]    = (rx_fill >= HALF_FILL);
        rd_data[16]    = !rx_empty;
        rd_data[15:12] = 4'(LGFLEN);
        rd_data[8:4]   = 5'(tx_fill);
        rd_data[1]     = (tx_fill <= HALF_FILL);
        rd_data[0]     = !tx_full;
      end
      2'd2: begin
        rd_data[12]  = rx_overflow;
        rd_data[11]  = rx_frame_err;
        rd_data[8]   = rx_empty;
        rd_data[7:0] = rx_empty ? 8'h00 : rx_head;
      end
      default: begin
        rd_data[12] = !cts_s;
        rd_data[9]  = tx_busy;
        rd_data[8]  = tx_full;
      end
    endcase
  end

  // Bus response: single-cycle ack with registered data.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack <= req;
      if (req) o_wb_data <= rd_data;
    end
  end

  // RTS asks the peer to pause once the receive FIFO is half full.
  always_ff @(posedge i_clk) begin
    if (i_reset) rts_q <= 1'b0;
    else         rts_q <= setup_flow && (rx_fill >= HALF_FILL);
  end

  assign o_wb_stall        = 1'b0;
  assign o_uart_tx         = tx_out;
  assign o_rts_n           = rts_q;
  assign o_uart_rx_int     = !rx_empty;
  assign o_uart_tx_int     = tx_empty && !tx_busy;
  assign o_uart_rxfifo_int = (rx_fill >= HALF_FILL);
  assign o_uart_txfifo_int = (tx_fill <= HALF_FILL);
endmodule

// File: tb/tb_wb_uart.sv
// Directed self-checking bench for wb_uart: bus timing, TX framing, CTS gating,
// RX framing/errors/overflow and RTS thresholds.
module tb_wb_uart;
  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic        stall, ack;
  logic [31:0] rdata;
  logic        rx_line, tx_line, cts_n, rts_n;
  logic        rx_int, tx_int, rxfifo_int, txfifo_int;

  int checks   = 0;
  int failures = 0;

  wb_uart dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_wb_cyc          (cyc),
    .i_wb_stb          (stb),
    .i_wb_we           (we),
    .i_wb_addr         (addr),
    .i_wb_data         (wdata),
    .i_wb_sel          (4'hF),
    .o_wb_stall        (stall),
    .o_wb_ack          (ack),
    .o_wb_data         (rdata),
    .i_uart_rx         (rx_line),
    .o_uart_tx         (tx_line),
    .i_cts_n           (cts_n),
    .o_rts_n           (rts_n),
    .o_uart_rx_int     (rx_int),
    .o_uart_tx_int     (tx_int),
    .o_uart_rxfifo_int (rxfifo_int),
    .o_uart_txfifo_int (txfifo_int)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    check("wr_ack", {31'b0, ack}, 32'd1);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    check("rd_ack", {31'b0, ack}, 32'd1);
    d = rdata;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
  endtask

  // Drive one 8N1 frame on the RX line with d clocks per bit.
  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int d);
    @(negedge clk);
    rx_line = 1'b0;
    repeat (d) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (d) @(negedge clk);
    end
    rx_line = stop_bit;
    repeat (d) @(negedge clk);
    rx_line = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    logic [9:0]  frame;
    logic        found;
    logic        saw_low;
    int          n;

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    rx_line = 1'b1; cts_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Reset state
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_data", rdata, 32'd0);
    check("rst_pins", {28'b0, tx_line, rts_n, stall, 1'b0}, {28'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    check("rst_ints", {28'b0, rx_int, tx_int, rxfifo_int, txfifo_int}, 32'b0101);

    // Ack exactly one cycle after the request
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 2'd0;
    #1 check("ack_req_cycle", {31'b0, ack}, 32'd0);
    @(posedge clk); #1;
    check("ack_next_cycle", {31'b0, ack}, 32'd1);
    check("setup_reset", rdata, 32'h4000_0364);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check("ack_single", {31'b0, ack}, 32'd0);
    wb_read(2'd1, d);
    check("fifo_reset", d, 32'h4000_4003);

    // TX frame at the minimum divisor
    wb_write(2'd0, 32'd1);
    wb_write(2'd3, 32'h0000_00A5);
    check("tx_int_drop", {31'b0, tx_int}, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(posedge clk); #1;
      if (!tx_line) found = 1'b1;
    end
    check("tx_start_seen", {31'b0, found}, 32'd1);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      check($sformatf("tx_bit%0d", k), {31'b0, tx_line}, {31'b0, frame[k]});
      if (k == 5) check("tx_int_busy", {31'b0, tx_int}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
    end
    check("tx_int_return", {31'b0, tx_int}, 32'd1);
    check("tx_idle_high", {31'b0, tx_line}, 32'd1);

    // Flow control: CTS high holds the byte, CTS low releases it
    cts_n = 1'b1;
    wb_write(2'd0, 32'h4000_0002);
    repeat (3) @(posedge clk);
    wb_write(2'd3, 32'h0000_005A);
    saw_low = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (!tx_line) saw_low = 1'b1;
    end
    check("cts_hold", {31'b0, saw_low}, 32'd0);
    wb_read(2'd3, d);
    check("txdata_cts_high", d, 32'h0000_0000);
    @(negedge clk) cts_n = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 6) begin
      @(posedge clk); #1;
      n++;
      if (!tx_line) found = 1'b1;
    end
    check("cts_release_3clk", {31'b0, (found && n <= 3)}, 32'd1);
    repeat (25) @(posedge clk);
    wb_read(2'd3, d);
    check("txdata_cts_low", d, 32'h0000_1000);

    // RX with divisor 4
    wb_write(2'd0, 32'd4);
    send_rx(8'h3C, 1'b1, 4);
    repeat (3) @(posedge clk); #1;
    check("rx_int_set", {31'b0, rx_int}, 32'd1);
    wb_read(2'd2, d);
    check("rx_byte", d, 32'h0000_003C);
    wb_read(2'd2, d);
    check("rx_empty", d, 32'h0000_0100);
    check("rx_int_clear", {31'b0, rx_int}, 32'd0);

    // Framing error: byte dropped, sticky set, cleared by a write
    send_rx(8'h77, 1'b0, 4);
    repeat (4) @(posedge clk); #1;
    check("ferr_no_push", {31'b0, rx_int}, 32'd0);
    wb_read(2'd2, d);
    check("ferr_sticky", d, 32'h0000_0900);
    wb_write(2'd2, 32'd0);
    wb_read(2'd2, d);
    check("ferr_cleared", d, 32'h0000_0100);

    // RTS and half-full interrupt with flow enabled
    wb_write(2'd0, 32'h4000_0004);
    for (int i = 0; i < 8; i++) send_rx(8'h40 + 8'(i), 1'b1, 4);
    repeat (3) @(posedge clk); #1;
    check("rts_half", {31'b0, rts_n}, 32'd1);
    check("rxfifo_int_half", {31'b0, rxfifo_int}, 32'd1);
    wb_read(2'd1, d);
    check("fifo_rx8", d, 32'h4083_4003);
    wb_read(2'd2, d);
    check("rx_pop_first", d, 32'h0000_0040);
    repeat (2) @(posedge clk); #1;
    check("rts_below", {31'b0, rts_n}, 32'd0);
    check("rxfifo_int_below", {31'b0, rxfifo_int}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      wb_read(2'd2, d);
      check($sformatf("rx_drain%0d", i), d, 32'h40 + 32'(i));
    end

    // Overflow: 17 frames into a 16-deep FIFO
    wb_write(2'd0, 32'd4);
    for (int i = 0; i < 17; i++) send_rx(8'h10 + 8'(i), 1'b1, 4);
    repeat (3) @(posedge clk); #1;
    check("rts_flow_off", {31'b0, rts_n}, 32'd0);
    wb_read(2'd1, d);
    check("fifo_rx_full", d, 32'h4103_4003);
    wb_read(2'd2, d);
    check("rx_overflow", d, 32'h0000_1010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
